// File: rtl/fft_out_reorder.sv
// fft_out_reorder
//   Output-side reorder buffer for the 4-lane parallel FFT core. Each accepted
//   beat carries four lane samples in the core's bit-reversed sequence. They
//   are scattered into a ping-pong pair of N-word banks at their natural-order
//   addresses. A full bank is then drained one natural-order bin per clock on a
//   valid/ready stream. Data passes through bit-exact.
//
//   Optional feature macro: FFT_REORDER_LAST_EN adds out_last. It is high with
//   the bin at out_index == N-1.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   in_valid   beat of four lane samples present
//   in_ready   a beat can be accepted this cycle
//   in_lane0-3 {re,im} for core outputs out0_up, out0_down, out1_up, out1_down
//   out_valid  out_data / out_index hold a bin
//   out_ready  downstream accepts the bin
//   out_data   {re,im} of bin out_index
//   out_index  natural bin number 0..N-1
//   out_last   (FFT_REORDER_LAST_EN only) bin N-1 of a frame
module fft_out_reorder #(
    parameter int NBITS_OUT = 15,
    parameter int N         = 32,
    parameter int LOGN      = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2*NBITS_OUT-1:0] in_lane0,
    input  logic [2*NBITS_OUT-1:0] in_lane1,
    input  logic [2*NBITS_OUT-1:0] in_lane2,
    input  logic [2*NBITS_OUT-1:0] in_lane3,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*NBITS_OUT-1:0] out_data,
    output logic [LOGN-1:0]        out_index
`ifdef FFT_REORDER_LAST_EN
    ,
    output logic                   out_last
`endif
);

    localparam int W  = 2*NBITS_OUT;
    localparam int BW = LOGN-2;
    localparam logic [BW-1:0]   B_LAST = BW'(N/4-1);
    localparam logic [LOGN-1:0] A_LAST = LOGN'(N-1);

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
        logic [LOGN-1:0] r;
        r = '0;
        for (int i = 0; i < LOGN; i++) begin
            r[i] = v[LOGN-1-i];
        end
        return r;
    endfunction

    // Both banks in one array, addressed {bank, addr}. The array has no
    // reset: a bank is only read after it has been completely rewritten.
    logic [W-1:0] bank_mem [2*N];

    logic [BW-1:0]   b_q, b_d;
    logic            wbank_q, wbank_d;
    logic            rbank_q, rbank_d;
    logic [1:0]      full_q, full_d;
    logic [LOGN-1:0] raddr_q, raddr_d;
    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_data_q, out_data_d;
    logic [LOGN-1:0] out_index_q, out_index_d;
`ifdef FFT_REORDER_LAST_EN
    logic            out_last_q, out_last_d;
`endif

    logic wr_fire, wr_done, out_hs, rd_release, rd_bank, rd_fire;

    assign in_ready   = ~full_q[wbank_q];
    assign wr_fire    = in_valid & in_ready;
    assign wr_done    = wr_fire & (b_q == B_LAST);
    assign out_hs     = out_valid_q & out_ready;
    assign rd_release = out_hs & (out_index_q == A_LAST);
    // When the last bin of a bank hands off, the read address has already
    // wrapped to 0. The register can then refill straight from the other bank
    // with no bubble between frames.
    assign rd_bank    = rd_release ? ~rbank_q : rbank_q;
    assign rd_fire    = (~out_valid_q | out_ready) & full_q[rd_bank];

    always_comb begin
        b_d         = b_q;
        wbank_d     = wbank_q;
        rbank_d     = rbank_q;
        full_d      = full_q;
        raddr_d     = raddr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
`ifdef FFT_REORDER_LAST_EN
        out_last_d  = out_last_q;
`endif
        if (wr_fire) begin
            b_d = b_q + BW'(1);
        end
        // The writer only completes an empty bank and the reader only
        // releases a full one, so these two updates never target the same bit.
        if (rd_release) begin
            full_d[rbank_q] = 1'b0;
            rbank_d         = ~rbank_q;
        end
        if (wr_done) begin
            full_d[wbank_q] = 1'b1;
            wbank_d         = ~wbank_q;
        end
        if (rd_fire) begin
            out_valid_d = 1'b1;
            out_data_d  = bank_mem[{rd_bank, raddr_q}];
            out_index_d = raddr_q;
            raddr_d     = raddr_q + LOGN'(1);
`ifdef FFT_REORDER_LAST_EN
            out_last_d  = (raddr_q == A_LAST);
`endif
        end else if (out_hs) begin
            out_valid_d = 1'b0;
`ifdef FFT_REORDER_LAST_EN
            out_last_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            b_q         <= '0;
            wbank_q     <= 1'b0;
            rbank_q     <= 1'b0;
            full_q      <= 2'b00;
            raddr_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
`ifdef FFT_REORDER_LAST_EN
            out_last_q  <= 1'b0;
`endif
        end else begin
            b_q         <= b_d;
            wbank_q     <= wbank_d;
            rbank_q     <= rbank_d;
            full_q      <= full_d;
            raddr_q     <= raddr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
`ifdef FFT_REORDER_LAST_EN
            out_last_q  <= out_last_d;
`endif
        end
    end

    // Lane l of beat b is core sequence s = {l, b}. It lands at bitrev(s).
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            bank_mem[{wbank_q, bitrev({2'd0, b_q})}] <= in_lane0;
            bank_mem[{wbank_q, bitrev({2'd1, b_q})}] <= in_lane1;
            bank_mem[{wbank_q, bitrev({2'd2, b_q})}] <= in_lane2;
            bank_mem[{wbank_q, bitrev({2'd3, b_q})}] <= in_lane3;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
`ifdef FFT_REORDER_LAST_EN
    assign out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_fft_out_reorder.sv
// Testbench for fft_out_reorder (N=32, NBITS_OUT=15).
// The reference model collects each frame's samples by core sequence number.
// On frame completion it queues the natural-order bins (bin k = sample with
// sequence bitrev(k)). The model also tracks how many frames are buffered.
module tb_fft_out_reorder;
    localparam int NB   = 15;
    localparam int N    = 32;
    localparam int LOGN = 5;
    localparam int W    = 2*NB;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W-1:0]    in_lane0 = '0, in_lane1 = '0, in_lane2 = '0, in_lane3 = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [W-1:0]    out_data;
    logic [LOGN-1:0] out_index;
`ifdef FFT_REORDER_LAST_EN
    logic            out_last;
`endif

    fft_out_reorder #(.NBITS_OUT(NB), .N(N), .LOGN(LOGN)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_lane0(in_lane0), .in_lane1(in_lane1),
        .in_lane2(in_lane2), .in_lane3(in_lane3),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index)
`ifdef FFT_REORDER_LAST_EN
        , .out_last(out_last)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int brev(input int v);
        int r = 0;
        for (int i = 0; i < LOGN; i++)
            if ((v >> i) & 1) r |= 1 << (LOGN-1-i);
        return r;
    endfunction

    // ---------------- reference model ----------------
    int           exp_idx[$];
    logic [W-1:0] exp_data[$];
    int           pend_idx[$];
    logic [W-1:0] pend_data[$];
    logic [W-1:0] seqv [N];
    logic [W-1:0] seen_data [N];
    int bcnt = 0, buffered = 0, released = 0, accepted = 0, bins_out = 0;
    int cyc = 0, done_cyc = -1, first_valid_cyc = -1, run = 0, max_run = 0, last_hi = 0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;

    // Samples sit here between edges, when every input and output is stable.
    // A handshake seen here takes effect on the next rising edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            exp_idx.delete(); exp_data.delete();
            pend_idx.delete(); pend_data.delete();
            bcnt = 0; buffered = 0; run = 0; prev_stall = 1'b0;
        end else begin
            check("in_ready", {63'd0, in_ready}, {63'd0, buffered < 2});
            check("out_valid", {63'd0, out_valid}, {63'd0, exp_idx.size() > 0});
            if (out_valid && exp_idx.size() > 0) begin
                check("out_index", 64'(out_index), 64'(exp_idx[0]));
                check("out_data", 64'(out_data), 64'(exp_data[0]));
`ifdef FFT_REORDER_LAST_EN
                check("out_last", {63'd0, out_last}, {63'd0, exp_idx[0] == N-1});
`endif
            end
            if (prev_stall && out_valid)
                check("hold_data", 64'(out_data), 64'(prev_data));
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;

            // Frames completed on the previous edge become visible one edge later.
            while (pend_idx.size() > 0) begin
                exp_idx.push_back(pend_idx.pop_front());
                exp_data.push_back(pend_data.pop_front());
            end

            if (out_valid && out_ready) begin
                run++;
                if (run > max_run) max_run = run;
                bins_out++;
                seen_data[out_index] = out_data;
`ifdef FFT_REORDER_LAST_EN
                if (out_last) last_hi++;
`endif
                if (exp_idx.size() > 0) begin
                    if (exp_idx[0] == N-1) begin
                        buffered--;
                        released++;
                    end
                    void'(exp_idx.pop_front());
                    void'(exp_data.pop_front());
                end
            end else begin
                run = 0;
            end

            if (in_valid && in_ready) begin
                accepted++;
                seqv[0*(N/4)+bcnt] = in_lane0;
                seqv[1*(N/4)+bcnt] = in_lane1;
                seqv[2*(N/4)+bcnt] = in_lane2;
                seqv[3*(N/4)+bcnt] = in_lane3;
                bcnt++;
                if (bcnt == N/4) begin
                    for (int k = 0; k < N; k++) begin
                        pend_idx.push_back(k);
                        pend_data.push_back(seqv[brev(k)]);
                    end
                    bcnt = 0;
                    buffered++;
                    done_cyc = cyc;
                end
            end
        end
    end

    // ---------------- out_ready driver ----------------
    int rmode = 3;   // 0: always 1, 1: pattern 1,0,0,1, 2: random, 3: always 0
    int rphase = 0;
    initial begin
        forever begin
            @(posedge clk); #1;
            case (rmode)
                0: out_ready = 1'b1;
                1: begin out_ready = (rphase % 4 == 0) || (rphase % 4 == 3); rphase++; end
                2: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [W-1:0] lane_val(input int s, input int mode);
        logic [NB-1:0] re, im;
        if (mode == 0) begin
            re = NB'(s);
            im = NB'(-s);
            return {re, im};
        end
        return W'($urandom);
    endfunction

    task automatic send_beat(input logic [W-1:0] l0, l1, l2, l3);
        int t = 0;
        logic acc = 1'b0;
        in_valid = 1'b1;
        in_lane0 = l0; in_lane1 = l1; in_lane2 = l2; in_lane3 = l3;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            t++;
            if (!acc && t > 400) begin
                check("beat_timeout", 64'(t), 64'd0);
                break;
            end
        end
    endtask

    task automatic send_frame(input int mode, input int max_gap);
        for (int b = 0; b < N/4; b++) begin
            if (max_gap > 0) begin
                int g = $urandom_range(0, max_gap);
                if (g > 0) begin
                    in_valid = 1'b0;
                    repeat (g) @(posedge clk);
                    #1;
                end
            end
            send_beat(lane_val(0*(N/4)+b, mode), lane_val(1*(N/4)+b, mode),
                      lane_val(2*(N/4)+b, mode), lane_val(3*(N/4)+b, mode));
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_idx.size() > 0 || pend_idx.size() > 0) && t < 3000) begin
            @(negedge clk); #1;
            t++;
        end
        if (t >= 3000) check("drain_timeout", 64'(t), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    int a0, b0, r0, t;

    initial begin
        // Test 1a: state held in reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_index", 64'(out_index), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Test 2: single counting frame with out_ready held high
        rmode = 0;
        repeat (2) @(posedge clk); #1;
        first_valid_cyc = -1; max_run = 0;
        send_frame(0, 0);
        wait_drain();
        // Last beat sampled at negedge i is taken at the next edge; out_valid
        // appears after the edge following that one, i.e. at negedge i+2.
        check("latency", 64'(first_valid_cyc - done_cyc), 64'd2);
        check("back_to_back", 64'(max_run), 64'd32);
        check("bin0", 64'(seen_data[0]), 64'd0);
        check("bin1", 64'(seen_data[1]), 64'({15'd16, 15'h7FF0}));
        check("bin31", 64'(seen_data[31]), 64'({15'd31, 15'h7FE1}));

        // Test 3: backpressure pattern 1,0,0,1
        rmode = 1;
        b0 = bins_out;
        send_frame(0, 0);
        wait_drain();
        check("bp_bins", 64'(bins_out - b0), 64'd32);

        // Test 4: ping-pong full with out_ready low
        rmode = 3;
        repeat (2) @(posedge clk); #1;
        a0 = accepted;
        in_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            in_lane0 = W'($urandom); in_lane1 = W'($urandom);
            in_lane2 = W'($urandom); in_lane3 = W'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("pp_accepted", 64'(accepted - a0), 64'd16);
        check("pp_in_ready", {63'd0, in_ready}, 64'd0);
        r0 = released; b0 = bins_out;
        rmode = 0;
        t = 0;
        while (released == r0 && t < 200) begin
            @(negedge clk); #1;
            t++;
        end
        check("pp_release_seen", {63'd0, released != r0}, 64'd1);
        check("pp_handshakes", 64'(bins_out - b0), 64'd32);
        @(negedge clk);
        check("pp_in_ready_back", {63'd0, in_ready}, 64'd1);
        wait_drain();

        // Test 5: continuous streaming, 10 random frames
        rmode = 0;
        max_run = 0;
        for (int f = 0; f < 10; f++) send_frame(1, 0);
        wait_drain();
        check("stream_run", 64'(max_run), 64'd320);

        // Random gaps on both sides
        rmode = 2;
        b0 = bins_out;
        for (int f = 0; f < 4; f++) send_frame(1, 2);
        rmode = 0;
        wait_drain();
        check("rand_bins", 64'(bins_out - b0), 64'd128);

        // Test 6 (with test 1b): reset mid-run with a stalled bin and a partial frame
        rmode = 3;
        send_frame(1, 0);
        for (int b = 0; b < 3; b++)
            send_beat(W'($urandom), W'($urandom), W'($urandom), W'($urandom));
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        check("async_in_ready", {63'd0, in_ready}, 64'd1);
        check("async_out_valid", {63'd0, out_valid}, 64'd0);
        check("async_out_data", 64'(out_data), 64'd0);
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        rmode = 0;
        b0 = bins_out;
        last_hi = 0;
        for (int k = 0; k < N; k++) seen_data[k] = '1;
        send_frame(0, 0);
        wait_drain();
        check("clean_bins", 64'(bins_out - b0), 64'd32);
        check("clean_bin1", 64'(seen_data[1]), 64'({15'd16, 15'h7FF0}));
        check("clean_bin6", 64'(seen_data[6]), 64'({15'd12, 15'h7FF4}));
`ifdef FFT_REORDER_LAST_EN
        check("last_count", 64'(last_hi), 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog time=%0t", $time);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
